// File: rtl/load_complete_queue.sv
// rtl/load_complete_queue.sv - FIFO holding completed load results until the CDB accepts them
module load_complete_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_from_lsq,
    input  logic [31:0]                in_data,
    input  logic [31:0]                in_pc,
    input  logic [TAG_W-1:0]           in_rob_idx,
    input  logic [TAG_W-1:0]           in_prd,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       cdb_req,
    input  logic                       cdb_grant,
    output logic [31:0]                cdb_data,
    output logic [31:0]                cdb_pc,
    output logic [TAG_W-1:0]           cdb_rob_idx,
    output logic [TAG_W-1:0]           cdb_prd,
    output logic                       cdb_wen,
    output logic                       cdb_from_lsq,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Entry storage is never reset; outputs are masked by the empty check instead.
    logic [31:0]      mem_data   [DEPTH];
    logic [31:0]      mem_pc     [DEPTH];
    logic [TAG_W-1:0] mem_rob    [DEPTH];
    logic [TAG_W-1:0] mem_prd    [DEPTH];
    logic             mem_lsq    [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             not_empty;
    logic             pop_ok;
    logic             push;
    logic             pop;

    assign not_empty = (count != '0);
    assign pop_ok    = not_empty && cdb_grant;
    // A full queue can still take an entry when the head leaves in the same cycle.
    assign in_ready  = (count < FULL_CNT) || pop_ok;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = pop_ok && !flush;

    // Present the head entry to the CDB, forced to zero when nothing is queued.
    always_comb begin
        cdb_req      = not_empty;
        cdb_data     = '0;
        cdb_pc       = '0;
        cdb_rob_idx  = '0;
        cdb_prd      = '0;
        cdb_from_lsq = 1'b0;
        if (not_empty) begin
            cdb_data     = mem_data[head];
            cdb_pc       = mem_pc[head];
            cdb_rob_idx  = mem_rob[head];
            cdb_prd      = mem_prd[head];
            cdb_from_lsq = mem_lsq[head];
        end
        // Physical register 0 is hardwired; the ROB still completes, but no RF write.
        cdb_wen = not_empty && (cdb_prd != '0);
    end

    // Write the incoming load result into the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[tail] <= in_data;
            mem_pc[tail]   <= in_pc;
            mem_rob[tail]  <= in_rob_idx;
            mem_prd[tail]  <= in_prd;
            mem_lsq[tail]  <= in_from_lsq;
        end
    end

    // Pointer, occupancy and sticky-overflow bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
